fetch_stage: RTL and testbench

Instruction-fetch stage directly upstream of the decoder. It owns the program counter and issues word reads to a synchronous instruction memory with 1-cycle read latency. It presents `ir` and `pc1` to the decoder. It holds its output under a downstream stall using a one-entry skid buffer, and squashes in-flight fetches on a branch/jump redirect. Bubbles are emitted as the canonical NOP (addi x0,x0,0), so the decoder needs no valid input.

---
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle-latency synchronous
// instruction memory, and feeds ir/pc1 to the decoder. A downstream stall
// parks the in-flight read in a one-entry skid buffer, so releasing the stall
// inserts no bubble. A redirect squashes the in-flight read and the skid entry.
// Bubbles and squashed slots are the canonical NOP, so the decoder can
// ignore ir_valid.
//
// Handshake: ir/pc1/ir_valid are registered. The decoder consumes them on
// every edge where stall=0. While stall=1 they hold. This is a valid/ready
// pair with ready = ~stall and no combinational path from stall to the
// outputs. imem_en=1 means a read of imem_addr is issued at this edge. Its
// data is on imem_rdata during the following cycle only.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc1,
  output logic        ir_valid
);

  logic [31:0] pc;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        sk_valid;
  logic [31:0] sk_ir;
  logic [31:0] sk_pc;

  // Issue a read whenever the stage advances: not in reset, stall or redirect.
  assign imem_en   = ~rst & ~stall & ~redirect_valid;
  assign imem_addr = pc;

  // PC, in-flight request, skid entry and output registers.
  // Priority: reset > redirect > stall > normal advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      req_valid <= 1'b0;
      req_pc    <= 32'h0;
      sk_valid  <= 1'b0;
      sk_ir     <= 32'h0;
      sk_pc     <= 32'h0;
      ir        <= NOP_INSN;
      pc1       <= 32'h0;
      ir_valid  <= 1'b0;
    end else if (redirect_valid) begin
      // Word-align the target. In-flight and skid data are both dropped.
      pc        <= {redirect_pc[31:2], 2'b00};
      req_valid <= 1'b0;
      sk_valid  <= 1'b0;
      ir        <= NOP_INSN;
      ir_valid  <= 1'b0;
    end else if (stall) begin
      // The memory will not hold its data, so park the in-flight word.
      if (req_valid) begin
        sk_ir     <= imem_rdata;
        sk_pc     <= req_pc;
        sk_valid  <= 1'b1;
        req_valid <= 1'b0;
      end
    end else begin
      // The skid entry is older than any new read, so it is presented first.
      if (sk_valid) begin
        ir       <= sk_ir;
        pc1      <= sk_pc;
        ir_valid <= 1'b1;
        sk_valid <= 1'b0;
      end else if (req_valid) begin
        ir       <= imem_rdata;
        pc1      <= req_pc;
        ir_valid <= 1'b1;
      end else begin
        // imem_rdata is not sampled here, so a stale or X value cannot leak.
        ir       <= NOP_INSN;
        ir_valid <= 1'b0;
      end
      req_pc    <= pc;
      req_valid <= 1'b1;
      pc        <= pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage. A directed vector table covers reset, stall/skid,
// redirect, redirect-under-stall, address wrap and mid-stream reset.
// A random-stall streaming phase then checks ordering against a queue of
// issued addresses.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] pc1;
  logic        ir_valid;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  fetch_stage #(.RESET_PC(RPC), .NOP_INSN(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .ir             (ir),
    .pc1            (pc1),
    .ir_valid       (ir_valid)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction contents are a fixed function of the address.
  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  // Synchronous memory with 1-cycle latency. It returns junk when not enabled.
  always @(posedge clk) imem_rdata <= imem_en ? insn_of(imem_addr) : JUNK;

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] rpc);
    rst = r;
    stall = s;
    redirect_valid = rv;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("invariant_sk_req", {31'd0, dut.sk_valid & dut.req_valid}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        r;
    logic        s;
    logic        rv;
    logic [31:0] rpc;
    logic        en;
    logic        chk_addr;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc1;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                              input logic en, input logic ca, input logic [31:0] addr,
                              input logic v, input logic [31:0] p);
    vec_t t;
    t.r = r; t.s = s; t.rv = rv; t.rpc = rpc;
    t.en = en; t.chk_addr = ca; t.addr = addr; t.v = v; t.pc1 = p;
    return t;
  endfunction

  vec_t vecs[26];

  initial begin
    logic [31:0] next_addr;
    logic [31:0] exp_pc1;
    logic [31:0] e;
    logic        exp_v;
    logic        s;
    int          had;

    // ---------- reset and directed table ----------
    // Reset, then stream A/B/C from 0x100.
    vecs[0]  = mk(1,0,0,32'h0,        0,0,32'h0,        0,32'h0);
    vecs[1]  = mk(1,0,0,32'h0,        0,1,32'h100,      0,32'h0);
    vecs[2]  = mk(0,0,0,32'h0,        1,1,32'h100,      0,32'h0);
    vecs[3]  = mk(0,0,0,32'h0,        1,1,32'h104,      1,32'h100);
    // Stall for 3 cycles while B is in flight.
    vecs[4]  = mk(0,1,0,32'h0,        0,1,32'h108,      1,32'h100);
    vecs[5]  = mk(0,1,0,32'h0,        0,1,32'h108,      1,32'h100);
    vecs[6]  = mk(0,1,0,32'h0,        0,1,32'h108,      1,32'h100);
    vecs[7]  = mk(0,0,0,32'h0,        1,1,32'h108,      1,32'h104);
    vecs[8]  = mk(0,0,0,32'h0,        1,1,32'h10C,      1,32'h108);
    vecs[9]  = mk(0,0,0,32'h0,        1,1,32'h110,      1,32'h10C);
    // Redirect to 0x200 while streaming.
    vecs[10] = mk(0,0,1,32'h200,      0,1,32'h114,      0,32'h10C);
    vecs[11] = mk(0,0,0,32'h0,        1,1,32'h200,      0,32'h10C);
    vecs[12] = mk(0,0,0,32'h0,        1,1,32'h204,      1,32'h200);
    vecs[13] = mk(0,0,0,32'h0,        1,1,32'h208,      1,32'h204);
    // Fill the skid, then redirect during the stall to an unaligned 0x203.
    vecs[14] = mk(0,1,0,32'h0,        0,1,32'h20C,      1,32'h204);
    vecs[15] = mk(0,1,1,32'h203,      0,1,32'h20C,      0,32'h204);
    vecs[16] = mk(0,0,0,32'h0,        1,1,32'h200,      0,32'h204);
    vecs[17] = mk(0,0,0,32'h0,        1,1,32'h204,      1,32'h200);
    // Redirect to the last word, so the next fetch wraps to address 0.
    vecs[18] = mk(0,0,1,32'hFFFF_FFFC,0,1,32'h208,      0,32'h200);
    vecs[19] = mk(0,0,0,32'h0,        1,1,32'hFFFF_FFFC,0,32'h200);
    vecs[20] = mk(0,0,0,32'h0,        1,1,32'h0,        1,32'hFFFF_FFFC);
    vecs[21] = mk(0,0,0,32'h0,        1,1,32'h4,        1,32'h0);
    // Reset pulsed mid-stream while stalled with the skid full.
    vecs[22] = mk(0,1,0,32'h0,        0,1,32'h8,        1,32'h0);
    vecs[23] = mk(1,1,0,32'h0,        0,1,32'h8,        0,32'h0);
    vecs[24] = mk(0,0,0,32'h0,        1,1,32'h100,      0,32'h0);
    vecs[25] = mk(0,0,0,32'h0,        1,1,32'h104,      1,32'h100);

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].rv, vecs[i].rpc);
      check($sformatf("v%0d_imem_en", i), {31'd0, imem_en}, {31'd0, vecs[i].en});
      if (vecs[i].chk_addr)
        check($sformatf("v%0d_imem_addr", i), imem_addr, vecs[i].addr);
      tick();
      check($sformatf("v%0d_ir_valid", i), {31'd0, ir_valid}, {31'd0, vecs[i].v});
      check($sformatf("v%0d_pc1", i), pc1, vecs[i].pc1);
      check($sformatf("v%0d_ir", i), ir, vecs[i].v ? insn_of(vecs[i].pc1) : NOP);
    end

    // ---------- random-stall streaming with an issue-order scoreboard ----------
    drive(0, 0, 1, 32'h400);
    tick();
    check("rs_redirect_valid", {31'd0, ir_valid}, 32'd0);
    exp_v     = 1'b0;
    exp_pc1   = 32'h100;
    next_addr = 32'h400;
    exp_q.delete();

    for (int c = 0; c < 300; c++) begin
      s = ($urandom_range(0, 99) < 35);
      drive(0, s, 0, 32'h0);
      check("rs_imem_en", {31'd0, imem_en}, {31'd0, ~s});
      had = exp_q.size();
      if (!s) begin
        check("rs_imem_addr", imem_addr, next_addr);
        exp_q.push_back(next_addr);
        next_addr = next_addr + 32'd4;
      end
      tick();
      if (!s) begin
        exp_v = (had > 0);
        if (had > 0) begin
          e = exp_q.pop_front();
          exp_pc1 = e;
        end
      end
      check("rs_ir_valid", {31'd0, ir_valid}, {31'd0, exp_v});
      check("rs_pc1", pc1, exp_pc1);
      check("rs_ir", ir, exp_v ? insn_of(exp_pc1) : NOP);
    end

    // ---------- report ----------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
